pc_cond_ctrl: RTL and testbench
===============================

Name: pc_cond_ctrl

Overview:
- Parametrised successor to the single-cycle PC-select logic.
- Adds registered NZCV condition flags, ARM condition-code evaluation and instruction gating.
- Adds a post-redirect flush counter for the pipelined core.
- Sits between the decoder and datapath. It produces the final PC-source select, gated register/memory write enables, and a squash window after every taken redirect.

Parameters:
- REG_ADDR_W, 4, width of destination register address.
- PC_REG, 15, register index that aliases the PC.
- FLUSH_CYCLES, 2, cycles squashed after a redirect (0..15; 0 disables flushing).
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  decoded instruction present this cycle.
- cond  in  4  ARM condition field.
- alu_flags  in  4  {N,Z,C,V} from ALU, current instruction.
- flag_w  in  2  [1]=update N,Z; [0]=update C,V.
- rd  in  REG_ADDR_W  destination register.
- reg_w  in  1  decoder register-write request.
- mem_w  in  1  decoder memory-write request.
- branch  in  1  decoder branch request.
- cond_ex  out  1  condition passes against flags_q (combinational).
- pc_src  out  1  select redirect target for next PC.
- reg_write  out  1  gated register write.
- mem_write  out  1  gated memory write.
- flush  out  1  one-cycle pulse, equals pc_src.
- flush_active  out  1  squash window in progress.
- flags_q  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset (async, rst_n=0):
  - flags_q=0000, flush counter=0.
  - All outputs 0 except cond_ex, which follows flags_q: AL still yields 1.
- cond_ex, evaluated from flags_q only, never alu_flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 → 0.
- ex = instr_valid & cond_ex & !flush_active.
- pc_src = ex & ((rd==PC_REG & reg_w) | branch).
- reg_write = ex & reg_w; mem_write = ex & mem_w. All three are combinational, zero latency.
- Flags register:
  - On a clock edge with ex=1: flag_w[1] loads N,Z from alu_flags; flag_w[0] loads C,V.
  - Otherwise hold. Squashed or cond-failed instructions never update flags.
- Flush counter (4-bit):
  - On an edge with pc_src=1, load FLUSH_CYCLES.
  - Else if nonzero, decrement.
  - flush_active = (counter != 0).
  - The instruction causing the redirect is not squashed. The next FLUSH_CYCLES instructions are squashed regardless of instr_valid.
- Boundaries:
  - pc_src cannot assert while flush_active, so there is no reload inside the window.
  - FLUSH_CYCLES=0: flush_active is constantly 0 and flush still pulses.
  - A redirect with flag_w set updates both flags and the counter on the same edge.
  - rst_n asserted mid-window clears the counter immediately.
  - instr_valid=0: all gated outputs 0, state held except the counter decrement.

Optional Feature:
- Macro PC_COND_STATS_EN.
- Defined: adds outputs taken_cnt[CNT_W] and squash_cnt[CNT_W].
  - taken_cnt increments on each edge with pc_src=1.
  - squash_cnt increments on each edge with instr_valid & flush_active.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package pc_cond_pkg holds:
  - condition-code localparams (COND_EQ..COND_AL, COND_NV);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - flag_w bit indices.
- One natural sub-module, cond_check: purely combinational, cond + flags → cond_ex.

Test Plan:
- Reset with cond=1110: flags_q=0000, cond_ex=1, flush_active=0. With rst_n=0 and branch=1, instr_valid=1: pc_src=0.
- Flags and EQ:
  - instr_valid=1, cond=AL, flag_w=11, alu_flags=0100 → next cycle flags_q=0100.
  - cond=EQ, reg_w=1, rd=3 → reg_write=1, pc_src=0.
  - cond=NE → reg_write=0.
- Redirect via PC write: cond=AL, reg_w=1, rd=15 → pc_src=1, flush=1.
  - Next 2 cycles: flush_active=1, reg_write=0 even with reg_w=1.
  - Third cycle: flush_active=0.
- Squashed flag update: during flush_active, flag_w=11, alu_flags=1001 → flags_q unchanged.
- Conditional branch: flags_q=1000 (N=1, V=0), cond=LT, branch=1 → pc_src=1; cond=GE → pc_src=0, mem_write=0 for mem_w=1.
- Reset mid-window: pc_src at cycle t, rst_n low at t+1 → flush_active=0 immediately. With PC_COND_STATS_EN defined, taken_cnt=0.

Source files
------------

// File: rtl/pc_cond_pkg.sv
// Shared constants for the PC-select / condition-gating block: ARM condition
// codes, NZCV bit positions and flag-write enable bit positions.
package pc_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/pc_cond_ctrl_cond_check.sv
// Combinational ARM condition-code evaluator: cond field + registered NZCV -> pass.
module cond_check
    import pc_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_cond_ctrl.sv
// PC-source select with registered NZCV flags, condition gating and a post-redirect
// squash window. Define PC_COND_STATS_EN to add saturating taken/squash counters.
module pc_cond_ctrl
    import pc_cond_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int PC_REG       = 15,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [3:0]            cond,
    input  logic [3:0]            alu_flags,
    input  logic [1:0]            flag_w,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_w,
    input  logic                  mem_w,
    input  logic                  branch,
    output logic                  cond_ex,
    output logic                  pc_src,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  flush,
    output logic                  flush_active,
    output logic [3:0]            flags_q
`ifdef PC_COND_STATS_EN
    ,
    output logic [CNT_W-1:0]      taken_cnt,
    output logic [CNT_W-1:0]      squash_cnt
`endif
);

    localparam logic [REG_ADDR_W-1:0] PC_IDX   = REG_ADDR_W'(PC_REG);
    localparam logic [3:0]            FLUSH_LD = 4'(FLUSH_CYCLES);

    logic       ex;
    logic [3:0] flags_d;
    logic [3:0] cnt_q, cnt_d;

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // Gated outputs are forced low while reset is held so nothing leaks downstream.
    always_comb begin
        flush_active = (cnt_q != 4'd0);
        ex           = rst_n & instr_valid & cond_ex & ~flush_active;
        pc_src       = ex & (((rd == PC_IDX) & reg_w) | branch);
        reg_write    = ex & reg_w;
        mem_write    = ex & mem_w;
        flush        = pc_src;

        flags_d = flags_q;
        if (ex && flag_w[FW_NZ]) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (ex && flag_w[FW_CV]) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end

        cnt_d = cnt_q;
        if (pc_src) begin
            cnt_d = FLUSH_LD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            cnt_q   <= 4'd0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_COND_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (pc_src && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
        end
        squash_cnt_d = squash_cnt_q;
        if (instr_valid && flush_active && (squash_cnt_q != {CNT_W{1'b1}})) begin
            squash_cnt_d = squash_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            taken_cnt_q  <= taken_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign taken_cnt  = taken_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_pc_cond_ctrl.sv
// Randomised self-checking bench for pc_cond_ctrl against an in-bench behavioural
// model, preceded by directed cases with hand-computed expectations.
module tb_pc_cond_ctrl;

    localparam int FLUSH = 2;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic [3:0] rd;
    logic       reg_w, mem_w, branch;
    logic       cond_ex, pc_src, reg_write, mem_write, flush, flush_active;
    logic [3:0] flags_q;
`ifdef PC_COND_STATS_EN
    logic [CNT_W-1:0] taken_cnt, squash_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state
    logic [3:0] m_flags;
    int         m_left;
    int         m_taken;
    int         m_squash;

    always #5 clk = ~clk;

    pc_cond_ctrl #(
        .REG_ADDR_W  (4),
        .PC_REG      (15),
        .FLUSH_CYCLES(FLUSH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_w      (flag_w),
        .rd          (rd),
        .reg_w       (reg_w),
        .mem_w       (mem_w),
        .branch      (branch),
        .cond_ex     (cond_ex),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .flush       (flush),
        .flush_active(flush_active),
        .flags_q     (flags_q)
`ifdef PC_COND_STATS_EN
        ,
        .taken_cnt   (taken_cnt),
        .squash_cnt  (squash_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // cond[3:1] picks a base predicate, cond[0] inverts it; 111x is always/never.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = (n == v) && !z;
            default: return !c[0];
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic model_out(output bit e_ce, output bit e_ex, output bit e_pc,
                             output bit e_rw, output bit e_mw, output bit e_fa);
        e_ce = cond_pass(cond, m_flags);
        e_fa = (m_left > 0);
        e_ex = rst_n && instr_valid && e_ce && !e_fa;
        e_pc = e_ex && ((rd == 4'd15 && reg_w) || branch);
        e_rw = e_ex && reg_w;
        e_mw = e_ex && mem_w;
    endtask

    task automatic model_reset();
        m_flags  = 4'b0000;
        m_left   = 0;
        m_taken  = 0;
        m_squash = 0;
    endtask

    task automatic model_edge();
        bit e_ce, e_ex, e_pc, e_rw, e_mw, e_fa;
        int sat;
        sat = (1 << CNT_W) - 1;
        if (!rst_n) begin
            model_reset();
        end else begin
            model_out(e_ce, e_ex, e_pc, e_rw, e_mw, e_fa);
            if (e_ex && flag_w[1]) m_flags[3:2] = alu_flags[3:2];
            if (e_ex && flag_w[0]) m_flags[1:0] = alu_flags[1:0];
            if (e_pc && m_taken < sat) m_taken++;
            if (instr_valid && e_fa && m_squash < sat) m_squash++;
            if (e_pc) m_left = FLUSH;
            else if (m_left > 0) m_left--;
        end
    endtask

    // Advance one clock: model follows the edge, new inputs may be driven afterwards.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        bit e_ce, e_ex, e_pc, e_rw, e_mw, e_fa;
        if (cmp_en) begin
            model_out(e_ce, e_ex, e_pc, e_rw, e_mw, e_fa);
            chk("cond_ex",      32'(cond_ex),      32'(e_ce));
            chk("pc_src",       32'(pc_src),       32'(e_pc));
            chk("flush",        32'(flush),        32'(e_pc));
            chk("reg_write",    32'(reg_write),    32'(e_rw));
            chk("mem_write",    32'(mem_write),    32'(e_mw));
            chk("flush_active", 32'(flush_active), 32'(e_fa));
            chk("flags_q",      32'(flags_q),      32'(m_flags));
`ifdef PC_COND_STATS_EN
            chk("taken_cnt",    32'(taken_cnt),    32'(m_taken));
            chk("squash_cnt",   32'(squash_cnt),   32'(m_squash));
`endif
        end
    end

    task automatic drive(input logic iv, input logic [3:0] c, input logic [3:0] af,
                         input logic [1:0] fw, input logic [3:0] r, input logic rw,
                         input logic mw, input logic br);
        instr_valid = iv; cond = c; alu_flags = af; flag_w = fw;
        rd = r; reg_w = rw; mem_w = mw; branch = br;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(1'b1, 4'b1110, 4'b0000, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("rst_flags_q", 32'(flags_q), 32'h0);
        chk("rst_cond_ex", 32'(cond_ex), 32'h1);
        chk("rst_flush_active", 32'(flush_active), 32'h0);
        chk("rst_pc_src", 32'(pc_src), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Load Z via an AL instruction, then test EQ/NE.
        drive(1'b1, 4'hE, 4'b0100, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("flags_after_al", 32'(flags_q), 32'b0100);
        drive(1'b1, 4'h0, 4'b0000, 2'b00, 4'd3, 1'b1, 1'b0, 1'b0);
        #1;
        chk("eq_reg_write", 32'(reg_write), 32'h1);
        chk("eq_pc_src", 32'(pc_src), 32'h0);
        cond = 4'h1;
        #1;
        chk("ne_reg_write", 32'(reg_write), 32'h0);

        // Redirect through a PC write, then the squash window.
        drive(1'b1, 4'hE, 4'b0000, 2'b00, 4'd15, 1'b1, 1'b0, 1'b0);
        #1;
        chk("redir_pc_src", 32'(pc_src), 32'h1);
        chk("redir_flush", 32'(flush), 32'h1);
        step();
        drive(1'b1, 4'hE, 4'b1001, 2'b11, 4'd3, 1'b1, 1'b0, 1'b0);
        #1;
        chk("win1_active", 32'(flush_active), 32'h1);
        chk("win1_reg_write", 32'(reg_write), 32'h0);
        step();
        chk("win2_active", 32'(flush_active), 32'h1);
        chk("win2_flags_held", 32'(flags_q), 32'b0100);
        step();
        chk("win_end", 32'(flush_active), 32'h0);
        chk("win_end_flags_held", 32'(flags_q), 32'b0100);

        // N=1, V=0 -> LT passes, GE fails.
        drive(1'b1, 4'hE, 4'b1000, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("flags_nv", 32'(flags_q), 32'b1000);
        drive(1'b1, 4'hB, 4'b0000, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("lt_pc_src", 32'(pc_src), 32'h1);
        drive(1'b1, 4'hA, 4'b0000, 2'b00, 4'd0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("ge_pc_src", 32'(pc_src), 32'h0);
        chk("ge_mem_write", 32'(mem_write), 32'h0);

        // Reset landing inside a squash window.
        drive(1'b1, 4'hE, 4'b0000, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk("pre_rst_active", 32'(flush_active), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_active", 32'(flush_active), 32'h0);
`ifdef PC_COND_STATS_EN
        chk("mid_rst_taken", 32'(taken_cnt), 32'h0);
`endif
        step();
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            instr_valid = ($urandom_range(0, 7) != 0);
            cond        = 4'($urandom_range(0, 15));
            alu_flags   = 4'($urandom);
            flag_w      = 2'($urandom);
            rd          = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            reg_w       = 1'($urandom);
            mem_w       = 1'($urandom);
            branch      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
